// File: rtl/sum_averager_pkg.sv
// sum_averager_pkg
// Shared definitions for the sum averager and later stages that consume the
// adder's output.
//   SUM_W   : width of the 4-input adder's sum, also the default sample width
//   state_t : block-fill state encoding
package sum_averager_pkg;

   localparam int SUM_W = 15;

   typedef enum logic {
      FILL = 1'b0,
      LAST = 1'b1
   } state_t;

endpackage : sum_averager_pkg

// File: rtl/sum_avg_outreg.sv
// sum_avg_outreg
// One-entry output register with a valid/ready handshake. A new value may be
// loaded whenever the slot is empty or is being drained in the same cycle.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   load       : capture load_data this cycle (caller honours can_load)
//   load_data  : value to capture
//   out_ready  : sink consumes out_data this cycle
//   out_data   : held result
//   out_valid  : out_data holds an unconsumed result
//   can_load   : slot free or draining now (combinational on out_ready)
module sum_avg_outreg #(
   parameter int W = 15
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] load_data,
   input  logic         out_ready,
   output logic [W-1:0] out_data,
   output logic         out_valid,
   output logic         can_load
);

   assign can_load = !out_valid || out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_data  <= '0;
         out_valid <= 1'b0;
      end else begin
         if (load) begin
            out_data  <= load_data;
            out_valid <= 1'b1;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule : sum_avg_outreg

// File: rtl/sum_averager.sv
// sum_averager
// Averages fixed blocks of 2^LOG2_N consecutive valid adder sums and presents
// the truncated mean through a one-entry valid/ready output register.
// Ports:
//   clk, rst_n          : clock, async active-low reset
//   in_valid, in_data   : sample input
//   in_ready            : sample accepted when in_valid && in_ready
//   out_data, out_valid : mean of the last completed block, handshake valid
//   out_ready           : sink takes out_data
//   block_cnt           : completed blocks since reset, wrapping
//
// state | meaning
// FILL  | idx < N-1, accumulating; never back-pressured
// LAST  | idx == N-1, final sample waits for a free output slot
module sum_averager
   import sum_averager_pkg::*;
#(
   parameter int IN_W   = SUM_W,
   parameter int LOG2_N = 2,
   parameter int CNT_W  = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [IN_W-1:0]  in_data,
   output logic             in_ready,
   output logic [IN_W-1:0]  out_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [CNT_W-1:0] block_cnt
);

   // N samples of IN_W bits sum to at most IN_W+LOG2_N bits, so no overflow.
   localparam int ACC_W = IN_W + LOG2_N;
   localparam logic [LOG2_N-1:0] LAST_IDX = '1;

   state_t            state;
   logic [ACC_W-1:0]  acc;
   logic [ACC_W-1:0]  sum_next;
   logic [LOG2_N-1:0] idx;
   logic [LOG2_N-1:0] idx_inc;
   logic [IN_W-1:0]   mean;
   logic              can_load;
   logic              accept;
   logic              load;

   assign sum_next = acc + ACC_W'(in_data);
   // Dropping the low LOG2_N bits is the divide-by-N, truncating toward zero.
   assign mean     = sum_next[ACC_W-1:LOG2_N];
   assign idx_inc  = idx + LOG2_N'(1);

   assign in_ready = (state == FILL) || can_load;
   assign accept   = in_valid && in_ready;
   assign load     = accept && (state == LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= FILL;
         acc       <= '0;
         idx       <= '0;
         block_cnt <= '0;
      end else if (accept) begin
         case (state)
            FILL: begin
               acc   <= sum_next;
               idx   <= idx_inc;
               state <= (idx_inc == LAST_IDX) ? LAST : FILL;
            end
            LAST: begin
               acc       <= '0;
               idx       <= '0;
               state     <= FILL;
               block_cnt <= block_cnt + CNT_W'(1);
            end
            default: state <= FILL;
         endcase
      end
   end

   sum_avg_outreg #(
      .W (IN_W)
   ) u_outreg (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (load),
      .load_data (mean),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_valid (out_valid),
      .can_load  (can_load)
   );

endmodule : sum_averager

// File: tb/tb_sum_averager.sv
module tb_sum_averager;

   localparam int IN_W   = 15;
   localparam int LOG2_N = 2;
   localparam int CNT_W  = 8;
   localparam int N      = 1 << LOG2_N;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             in_valid = 1'b0;
   logic [IN_W-1:0]  in_data = '0;
   logic             in_ready;
   logic [IN_W-1:0]  out_data;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [CNT_W-1:0] block_cnt;

   int checks = 0;
   int errors = 0;

   // Reference model: samples of the current block, output slot, block count.
   int m_q[$];
   bit m_valid;
   int m_data;
   int m_blocks;

   sum_averager #(
      .IN_W   (IN_W),
      .LOG2_N (LOG2_N),
      .CNT_W  (CNT_W)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .block_cnt (block_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic void m_reset();
      m_q.delete();
      m_valid  = 1'b0;
      m_data   = 0;
      m_blocks = 0;
   endfunction

   // Only the final sample of a block waits, and only for an occupied slot.
   function automatic bit m_in_ready(input bit r);
      return (m_q.size() < N-1) || !m_valid || r;
   endfunction

   task automatic check_outputs(input string tag);
      check({tag, "_out_valid"}, 32'(out_valid), 32'(m_valid));
      check({tag, "_out_data"},  32'(out_data),  m_data);
      check({tag, "_block_cnt"}, 32'(block_cnt), m_blocks);
   endtask

   // One clock: present inputs, check in_ready, clock, update model, check.
   task automatic cycle(input bit v, input int d, input bit r);
      bit acc_e;
      bit loaded;
      int s;
      in_valid  = v;
      in_data   = d[IN_W-1:0];
      out_ready = r;
      #1;
      check("in_ready", 32'(in_ready), 32'(m_in_ready(r)));
      acc_e = v && m_in_ready(r);
      @(posedge clk);
      #1;
      loaded = 1'b0;
      if (acc_e) begin
         m_q.push_back(d & ((1 << IN_W) - 1));
         if (m_q.size() == N) begin
            s = 0;
            foreach (m_q[k]) s += m_q[k];
            m_data   = s / N;
            m_valid  = 1'b1;
            m_blocks = (m_blocks + 1) % (1 << CNT_W);
            m_q.delete();
            loaded = 1'b1;
         end
      end
      if (!loaded && r) m_valid = 1'b0;
      check_outputs("cyc");
   endtask

   task automatic do_reset();
      in_valid  = 1'b0;
      out_ready = 1'b0;
      rst_n     = 1'b0;
      #2;
      m_reset();
      check_outputs("rst");
      check("rst_in_ready", 32'(in_ready), 32'd1);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      check_outputs("post_rst");
   endtask

   initial begin
      m_reset();
      #3;
      do_reset();

      // Plain block of identical samples, then one idle cycle to drain.
      for (int i = 0; i < N; i++) cycle(1, 4444, 1);
      check("blk4444_data", 32'(out_data), 32'd4444);
      check("blk4444_cnt", 32'(block_cnt), 32'd1);
      cycle(0, 0, 1);
      check("blk4444_drain", 32'(out_valid), 32'd0);

      // Largest adder sum.
      for (int i = 0; i < N; i++) cycle(1, 22220, 1);
      check("max_data", 32'(out_data), 32'd22220);

      // Truncation.
      cycle(1, 1, 1); cycle(1, 1, 1); cycle(1, 1, 1); cycle(1, 2, 1);
      check("trunc_a", 32'(out_data), 32'd1);
      cycle(1, 3, 1); cycle(1, 3, 1); cycle(1, 3, 1); cycle(1, 2, 1);
      check("trunc_b", 32'(out_data), 32'd2);
      cycle(0, 0, 1);

      // Backpressure: two blocks with the sink stalled.
      for (int i = 0; i < N; i++) cycle(1, 100, 0);
      for (int i = 0; i < N-1; i++) cycle(1, 200, 0);
      check("bp_hold", 32'(out_data), 32'd100);
      cycle(1, 200, 0);
      cycle(1, 200, 0);
      check("bp_stall_ready", 32'(in_ready), 32'd0);
      check("bp_still_100", 32'(out_data), 32'd100);
      cycle(1, 200, 1);
      check("bp_swap_data", 32'(out_data), 32'd200);
      check("bp_swap_valid", 32'(out_valid), 32'd1);
      cycle(0, 0, 1);

      // Reset in the middle of a block.
      cycle(1, 7000, 1);
      cycle(1, 7000, 1);
      do_reset();
      for (int i = 0; i < N; i++) cycle(1, 100, 1);
      check("midrst_data", 32'(out_data), 32'd100);
      check("midrst_cnt", 32'(block_cnt), 32'd1);

      // Random traffic with random stalls on both sides.
      for (int i = 0; i < 600; i++)
         cycle(bit'($urandom_range(1, 0)), int'($urandom_range(32767, 0)),
               bit'($urandom_range(3, 0) != 0));
      cycle(0, 0, 1);

      // Counter wrap after 2^CNT_W blocks at full rate.
      do_reset();
      for (int b = 0; b < (1 << CNT_W); b++)
         for (int i = 0; i < N; i++) cycle(1, int'($urandom_range(32767, 0)), 1);
      check("wrap_cnt", 32'(block_cnt), 32'd0);
      for (int i = 0; i < N; i++) cycle(1, 555, 1);
      check("wrap_after_data", 32'(out_data), 32'd555);
      check("wrap_after_cnt", 32'(block_cnt), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_sum_averager
